// File: rtl/semaforo_pkg.sv
// Shared definitions for the two-head traffic-light controller and its monitor:
// lamp encodings, monitor fault codes and default phase durations.
package semaforo_pkg;

  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] RED    = 3'b100;

  typedef enum logic [2:0] {
    F_NONE   = 3'd0,
    F_ONEHOT = 3'd1,
    F_SUCC   = 3'd2,
    F_EARLY  = 3'd3,
    F_OVER   = 3'd4,
    F_BLAMP  = 3'd5
  } fault_code_t;

  // Terminal counts; each phase lasts count+1 cycles.
  localparam int VERDE_DEF    = 8;
  localparam int AMARELO_DEF  = 3;
  localparam int VERMELHO_DEF = 6;

  function automatic logic lamp_is_onehot(input logic [2:0] lamp);
    logic ok;
    case (lamp)
      GREEN, YELLOW, RED: ok = 1'b1;
      default:            ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [2:0] lamp_successor(input logic [2:0] lamp);
    logic [2:0] nxt;
    case (lamp)
      GREEN:   nxt = YELLOW;
      YELLOW:  nxt = RED;
      RED:     nxt = GREEN;
      default: nxt = GREEN;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/semaforo_phase_decode.sv
// Combinational decode of the main-head sample against the last accepted phase:
// one-hot legality, legal-successor test and the run limit of the current phase.
module semaforo_phase_decode
  import semaforo_pkg::*;
#(
  parameter int VERDE    = VERDE_DEF,
  parameter int AMARELO  = AMARELO_DEF,
  parameter int VERMELHO = VERMELHO_DEF
) (
  input  logic [2:0] last_a,
  input  logic [2:0] a_lamp,
  output logic       is_onehot,
  output logic       is_successor,
  output logic [4:0] limit
);

  localparam logic [4:0] LIM_G = 5'(VERDE) + 5'd1;
  localparam logic [4:0] LIM_Y = 5'(AMARELO) + 5'd1;
  localparam logic [4:0] LIM_R = 5'(VERMELHO) + 5'd1;

  // Classify the sample and select the dwell limit of the phase being timed.
  always_comb begin
    is_onehot    = lamp_is_onehot(a_lamp);
    is_successor = (a_lamp == lamp_successor(last_a));
    case (last_a)
      GREEN:   limit = LIM_G;
      YELLOW:  limit = LIM_Y;
      RED:     limit = LIM_R;
      default: limit = LIM_G;
    endcase
  end

endmodule

// File: rtl/semaforo_monitor.sv
// Passive checker of the controller lamp outputs: sticky first-fault code,
// saturating violation count and a count of completed red-to-green rounds.
module semaforo_monitor
  import semaforo_pkg::*;
#(
  parameter int VERDE    = VERDE_DEF,
  parameter int AMARELO  = AMARELO_DEF,
  parameter int VERMELHO = VERMELHO_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  a_lamp,
  input  logic [2:0]  b_lamp,
  input  logic        clr_fault,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [7:0]  fault_cnt,
  output logic [15:0] rounds
);

  logic [2:0]  last_a;
  logic [4:0]  run;

  logic        is_onehot;
  logic        is_successor;
  logic [4:0]  limit;

  logic        changed;
  logic        any_fault;
  fault_code_t win_code;

  logic [2:0]  last_a_nxt;
  logic [4:0]  run_nxt;
  logic        fault_nxt;
  logic [2:0]  fault_code_nxt;
  logic [7:0]  fault_cnt_nxt;
  logic [15:0] rounds_nxt;

  semaforo_phase_decode #(
    .VERDE    (VERDE),
    .AMARELO  (AMARELO),
    .VERMELHO (VERMELHO)
  ) u_decode (
    .last_a       (last_a),
    .a_lamp       (a_lamp),
    .is_onehot    (is_onehot),
    .is_successor (is_successor),
    .limit        (limit)
  );

  // Evaluate all checks; the lowest-numbered firing check is reported.
  always_comb begin
    changed  = (a_lamp != last_a);
    win_code = F_NONE;
    if (!is_onehot) begin
      win_code = F_ONEHOT;
    end else if (changed && !is_successor) begin
      win_code = F_SUCC;
    end else if (changed && (run != limit)) begin
      win_code = F_EARLY;
    end else if (!changed && (run == limit)) begin
      win_code = F_OVER;
    end else if ((b_lamp != GREEN) && (b_lamp != a_lamp)) begin
      win_code = F_BLAMP;
    end else begin
      win_code = F_NONE;
    end
    any_fault = (win_code != F_NONE);
  end

  // Next-state computation for phase tracking, fault latch and counters.
  always_comb begin
    last_a_nxt     = last_a;
    run_nxt        = run;
    fault_nxt      = fault;
    fault_code_nxt = fault_code;
    fault_cnt_nxt  = fault_cnt;
    rounds_nxt     = rounds;

    if (any_fault) begin
      fault_cnt_nxt = (fault_cnt == 8'hFF) ? fault_cnt : fault_cnt + 8'd1;
      // A fresh fault overrides a simultaneous clear, replacing any held code.
      if (!fault || clr_fault) begin
        fault_nxt      = 1'b1;
        fault_code_nxt = win_code;
      end else begin
        fault_nxt      = fault;
        fault_code_nxt = fault_code;
      end
      // Resync onto the observed phase when it is at least a valid lamp code.
      if (is_onehot) begin
        last_a_nxt = a_lamp;
        run_nxt    = 5'd1;
      end else begin
        last_a_nxt = last_a;
        run_nxt    = run;
      end
    end else begin
      if (clr_fault) begin
        fault_nxt      = 1'b0;
        fault_code_nxt = 3'd0;
      end else begin
        fault_nxt      = fault;
        fault_code_nxt = fault_code;
      end
      if (changed) begin
        last_a_nxt = a_lamp;
        run_nxt    = 5'd1;
        if ((last_a == RED) && (a_lamp == GREEN)) begin
          rounds_nxt = rounds + 16'd1;
        end else begin
          rounds_nxt = rounds;
        end
      end else begin
        last_a_nxt = last_a;
        run_nxt    = run + 5'd1;
      end
    end
  end

  // State and output registers; reset returns to the controller's power-on phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_a     <= GREEN;
      run        <= 5'd0;
      fault      <= 1'b0;
      fault_code <= 3'd0;
      fault_cnt  <= 8'd0;
      rounds     <= 16'd0;
    end else begin
      last_a     <= last_a_nxt;
      run        <= run_nxt;
      fault      <= fault_nxt;
      fault_code <= fault_code_nxt;
      fault_cnt  <= fault_cnt_nxt;
      rounds     <= rounds_nxt;
    end
  end

endmodule

// File: tb/tb_semaforo_monitor.sv
// Directed bench for semaforo_monitor: a driver issues lamp samples and queues
// the hand-computed expected outputs; a monitor compares after every clock edge.
module tb_semaforo_monitor;
  import semaforo_pkg::*;

  logic        clk;
  logic        rst;
  logic [2:0]  a_lamp;
  logic [2:0]  b_lamp;
  logic        clr_fault;
  logic        fault;
  logic [2:0]  fault_code;
  logic [7:0]  fault_cnt;
  logic [15:0] rounds;

  typedef struct {
    logic        f;
    logic [2:0]  c;
    logic [7:0]  n;
    logic [15:0] r;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  semaforo_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .a_lamp     (a_lamp),
    .b_lamp     (b_lamp),
    .clr_fault  (clr_fault),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_cnt  (fault_cnt),
    .rounds     (rounds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: outputs settle just after each edge; pop one expectation per sample.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("fault", {15'd0, fault}, {15'd0, e.f});
      chk("fault_code", {13'd0, fault_code}, {13'd0, e.c});
      chk("fault_cnt", {8'd0, fault_cnt}, {8'd0, e.n});
      chk("rounds", rounds, e.r);
    end
  end

  task automatic step(input logic [2:0] a, input logic [2:0] b, input logic clr,
                      input logic f, input logic [2:0] c, input logic [7:0] n,
                      input logic [15:0] r);
    exp_t e;
    @(negedge clk);
    a_lamp    = a;
    b_lamp    = b;
    clr_fault = clr;
    e.f = f; e.c = c; e.n = n; e.r = r;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic phase(input logic [2:0] a, input int len, input logic f,
                       input logic [2:0] c, input logic [7:0] n, input logic [15:0] r);
    for (int i = 0; i < len; i++) step(a, GREEN, 1'b0, f, c, n, r);
  endtask

  initial begin
    rst       = 1'b1;
    a_lamp    = GREEN;
    b_lamp    = GREEN;
    clr_fault = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_fault", {15'd0, fault}, 16'd0);
    chk("reset_code", {13'd0, fault_code}, 16'd0);
    chk("reset_cnt", {8'd0, fault_cnt}, 16'd0);
    chk("reset_rounds", rounds, 16'd0);
    rst = 1'b0;

    // Three legal rounds; first round completes at edge 21.
    phase(GREEN, 9, 1'b0, 3'd0, 8'd0, 16'd0);
    for (int k = 1; k <= 3; k++) begin
      phase(YELLOW, 4, 1'b0, 3'd0, 8'd0, 16'(k - 1));
      phase(RED, 7, 1'b0, 3'd0, 8'd0, 16'(k - 1));
      phase(GREEN, 9, 1'b0, 3'd0, 8'd0, 16'(k));
    end

    // Green cut to 8 samples: early change, then a clean resynced round.
    phase(YELLOW, 4, 1'b0, 3'd0, 8'd0, 16'd3);
    phase(RED, 7, 1'b0, 3'd0, 8'd0, 16'd3);
    phase(GREEN, 8, 1'b0, 3'd0, 8'd0, 16'd4);
    step(YELLOW, GREEN, 1'b0, 1'b1, 3'd3, 8'd1, 16'd4);
    phase(YELLOW, 3, 1'b1, 3'd3, 8'd1, 16'd4);
    phase(RED, 7, 1'b1, 3'd3, 8'd1, 16'd4);
    phase(GREEN, 9, 1'b1, 3'd3, 8'd1, 16'd5);
    step(YELLOW, GREEN, 1'b1, 1'b0, 3'd0, 8'd1, 16'd5);
    phase(YELLOW, 3, 1'b0, 3'd0, 8'd1, 16'd5);

    // Non-one-hot sample; tracking holds, so the red that follows is on time.
    step(3'b011, GREEN, 1'b0, 1'b1, 3'd1, 8'd2, 16'd5);
    phase(RED, 7, 1'b1, 3'd1, 8'd2, 16'd5);
    step(GREEN, GREEN, 1'b1, 1'b0, 3'd0, 8'd2, 16'd6);
    phase(GREEN, 7, 1'b0, 3'd0, 8'd2, 16'd6);

    // Green (8 samples) straight to red: bad succession outranks early change.
    step(RED, GREEN, 1'b0, 1'b1, 3'd2, 8'd3, 16'd6);
    phase(RED, 6, 1'b1, 3'd2, 8'd3, 16'd6);
    step(GREEN, GREEN, 1'b1, 1'b0, 3'd0, 8'd3, 16'd7);
    phase(GREEN, 7, 1'b0, 3'd0, 8'd3, 16'd7);

    // Illegal secondary head, clear on a clean sample, then clear racing a new fault.
    step(GREEN, YELLOW, 1'b0, 1'b1, 3'd5, 8'd4, 16'd7);
    phase(GREEN, 8, 1'b1, 3'd5, 8'd4, 16'd7);
    step(YELLOW, GREEN, 1'b1, 1'b0, 3'd0, 8'd4, 16'd7);
    step(YELLOW, RED, 1'b0, 1'b1, 3'd5, 8'd5, 16'd7);
    step(RED, GREEN, 1'b1, 1'b1, 3'd3, 8'd6, 16'd7);
    phase(RED, 3, 1'b1, 3'd3, 8'd6, 16'd7);

    // Asynchronous reset mid-red: outputs clear before the next edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_fault", {15'd0, fault}, 16'd0);
    chk("async_code", {13'd0, fault_code}, 16'd0);
    chk("async_cnt", {8'd0, fault_cnt}, 16'd0);
    chk("async_rounds", rounds, 16'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    phase(GREEN, 9, 1'b0, 3'd0, 8'd0, 16'd0);
    step(YELLOW, GREEN, 1'b0, 1'b0, 3'd0, 8'd0, 16'd0);

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
